// File: rtl/rain_pkg.sv
// Shared types for the rain lane engine: game states, the per-lane slot record
// and the lane-index width helper.
package rain_pkg;

    typedef enum logic [1:0] {
        ST_WELCOME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_OVER    = 2'd2
    } state_t;

    // Slot fields are sized for the widest supported geometry; narrower
    // configurations zero-extend into them.
    localparam int Y_W_MAX   = 16;
    localparam int SPD_W_MAX = 8;

    typedef struct packed {
        logic                 active;
        logic [7:0]           ch;
        logic [SPD_W_MAX-1:0] speed;
        logic [Y_W_MAX-1:0]   y;
    } slot_t;

    function automatic int lane_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rain_lane_pick.sv
// Combinational lane selection: lowest free slot for spawning and the
// deepest matching slot (lowest index on a tie) for key removal.
module rain_lane_pick
    import rain_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int Y_W    = 10,
    parameter int LANE_W = lane_w(LANES)
) (
    input  logic [LANES-1:0]     active_vec,
    input  logic [LANES-1:0]     match_vec,
    input  logic [LANES*Y_W-1:0] y_flat,
    output logic [LANE_W-1:0]    free_idx,
    output logic                 any_free,
    output logic [LANE_W-1:0]    best_idx,
    output logic                 hit
);

    logic [Y_W-1:0] best_y;

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (!active_vec[i]) begin
                free_idx = LANE_W'(i);
                any_free = 1'b1;
            end
        end
    end

    // Strict greater-than keeps the earlier (lower) index when y values tie.
    always_comb begin
        best_idx = '0;
        best_y   = '0;
        hit      = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (match_vec[i] && (!hit || (y_flat[i*Y_W +: Y_W] > best_y))) begin
                best_idx = LANE_W'(i);
                best_y   = y_flat[i*Y_W +: Y_W];
                hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rain_lane_engine.sv
// Game-state core for the falling-character typing game: LANES character slots
// with spawn, key-match removal, tick advance, score/miss tracking and read port.
module rain_lane_engine
    import rain_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int Y_W        = 10,
    parameter int SPD_W      = 3,
    parameter int BOTTOM     = 480,
    parameter int MISS_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     tick,
    input  logic                     spawn_valid,
    output logic                     spawn_ready,
    input  logic [7:0]               spawn_char,
    input  logic [SPD_W-1:0]         spawn_speed,
    input  logic [Y_W-1:0]           spawn_y,
    input  logic                     key_valid,
    input  logic [7:0]               key_char,
    input  logic [lane_w(LANES)-1:0] rd_lane,
    output logic                     rd_active,
    output logic [7:0]               rd_char,
    output logic [Y_W-1:0]           rd_y,
    output logic [1:0]               state,
    output logic [7:0]               score,
    output logic [7:0]               misses,
    output logic                     gameover
);

    localparam int LANE_W  = lane_w(LANES);
    localparam int NSLOT   = 1 << LANE_W;
    localparam int Y_RANGE = 1 << Y_W;
    localparam int MISS_Y  = (BOTTOM < Y_RANGE) ? BOTTOM : Y_RANGE;
    localparam logic [Y_W_MAX:0] MISS_Y_V = (Y_W_MAX + 1)'(MISS_Y);

    state_t cur_state, next_state;
    slot_t  slots [NSLOT];

    logic [LANES-1:0]     active_vec, match_vec, lost;
    logic [LANES*Y_W-1:0] y_flat;
    logic [LANE_W-1:0]    free_idx, best_idx;
    logic                 any_free, hit, play, spawn_fire;
    logic [Y_W_MAX:0]     y_sum [LANES];
    logic [6:0]           lost_count;
    logic [8:0]           miss_sum;
    logic [7:0]           next_misses;
    logic [SPD_W-1:0]     spawn_spd_eff;

    always_comb begin
        active_vec = '0;
        match_vec  = '0;
        y_flat     = '0;
        for (int i = 0; i < LANES; i++) begin
            active_vec[i]          = slots[i].active;
            match_vec[i]           = play && key_valid && slots[i].active && (slots[i].ch == key_char);
            y_flat[i*Y_W +: Y_W]   = slots[i].y[Y_W-1:0];
        end
    end

    rain_lane_pick #(
        .LANES  (LANES),
        .Y_W    (Y_W),
        .LANE_W (LANE_W)
    ) u_pick (
        .active_vec (active_vec),
        .match_vec  (match_vec),
        .y_flat     (y_flat),
        .free_idx   (free_idx),
        .any_free   (any_free),
        .best_idx   (best_idx),
        .hit        (hit)
    );

    // Sum is one bit wider than the stored y so a wrap past the top counts as a miss.
    always_comb begin
        lost       = '0;
        lost_count = '0;
        for (int i = 0; i < LANES; i++) begin
            y_sum[i] = {1'b0, slots[i].y} + (Y_W_MAX + 1)'(slots[i].speed);
            lost[i]  = play && tick && slots[i].active && !(hit && (best_idx == LANE_W'(i)))
                       && (y_sum[i] >= MISS_Y_V);
            lost_count = lost_count + 7'(lost[i]);
        end
        miss_sum    = 9'(misses) + 9'(lost_count);
        next_misses = (miss_sum >= 9'(MISS_LIMIT)) ? 8'(MISS_LIMIT) : miss_sum[7:0];
    end

    assign play          = (cur_state == ST_PLAY);
    assign spawn_ready   = play && any_free;
    assign spawn_fire    = spawn_valid && spawn_ready;
    assign spawn_spd_eff = (spawn_speed == '0) ? SPD_W'(1) : spawn_speed;
    assign state         = cur_state;
    assign gameover      = (cur_state == ST_OVER);

    always_ff @(posedge clk) begin
        if (rst) cur_state <= ST_WELCOME;
        else     cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_WELCOME: if (start) next_state = ST_PLAY;
            ST_PLAY:    if (next_misses == 8'(MISS_LIMIT)) next_state = ST_OVER;
            ST_OVER:    if (start) next_state = ST_WELCOME;
            default:    next_state = ST_WELCOME;
        endcase
    end

    // Removal wins over advance; a spawn only ever lands in a slot that was idle.
    always_ff @(posedge clk) begin
        if (rst || (cur_state == ST_WELCOME && start)) begin
            for (int i = 0; i < NSLOT; i++) slots[i] <= '0;
            score  <= '0;
            misses <= '0;
        end else if (play) begin
            for (int i = 0; i < LANES; i++) begin
                if (hit && (best_idx == LANE_W'(i))) begin
                    slots[i].active <= 1'b0;
                end else if (lost[i]) begin
                    slots[i].active <= 1'b0;
                end else if (tick && slots[i].active) begin
                    slots[i].y <= y_sum[i][Y_W_MAX-1:0];
                end
                if (spawn_fire && (free_idx == LANE_W'(i))) begin
                    slots[i] <= slot_t'{active: 1'b1, ch: spawn_char,
                                        speed: SPD_W_MAX'(spawn_spd_eff), y: Y_W_MAX'(spawn_y)};
                end
            end
            if (hit && (score != 8'hFF)) score <= score + 8'd1;
            misses <= next_misses;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_active <= 1'b0;
            rd_char   <= '0;
            rd_y      <= '0;
        end else begin
            rd_active <= slots[rd_lane].active;
            rd_char   <= slots[rd_lane].ch;
            rd_y      <= slots[rd_lane].y[Y_W-1:0];
        end
    end

endmodule

// File: tb/tb_rain_lane_engine.sv
// Self-checking bench for rain_lane_engine (4 lanes, miss limit 1): a slot-level
// game model compared every cycle, plus hand-computed literal expectations.
module tb_rain_lane_engine;

    localparam int LANES      = 4;
    localparam int Y_W        = 10;
    localparam int SPD_W      = 3;
    localparam int BOTTOM     = 480;
    localparam int MISS_LIMIT = 1;

    logic                                 clk = 1'b0;
    logic                                 rst = 1'b1;
    logic                                 start = 1'b0, tick = 1'b0;
    logic                                 spawn_valid = 1'b0, spawn_ready;
    logic [7:0]                           spawn_char = '0;
    logic [SPD_W-1:0]                     spawn_speed = '0;
    logic [Y_W-1:0]                       spawn_y = '0;
    logic                                 key_valid = 1'b0;
    logic [7:0]                           key_char = '0;
    logic [rain_pkg::lane_w(LANES)-1:0]   rd_lane = '0;
    logic                                 rd_active;
    logic [7:0]                           rd_char;
    logic [Y_W-1:0]                       rd_y;
    logic [1:0]                           state;
    logic [7:0]                           score, misses;
    logic                                 gameover;

    always #5 clk = ~clk;

    rain_lane_engine #(
        .LANES(LANES), .Y_W(Y_W), .SPD_W(SPD_W), .BOTTOM(BOTTOM), .MISS_LIMIT(MISS_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_char(spawn_char),
        .spawn_speed(spawn_speed), .spawn_y(spawn_y),
        .key_valid(key_valid), .key_char(key_char),
        .rd_lane(rd_lane), .rd_active(rd_active), .rd_char(rd_char), .rd_y(rd_y),
        .state(state), .score(score), .misses(misses), .gameover(gameover)
    );

    int checks = 0;
    int errors = 0;

    // Game model: plain integer arrays, one entry per lane.
    int m_state = 0, m_score = 0, m_misses = 0;
    int m_act [LANES];
    int m_ch  [LANES];
    int m_spd [LANES];
    int m_y   [LANES];
    int e_rd_act = 0, e_rd_ch = 0, e_rd_y = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_clear_slots();
        for (int i = 0; i < LANES; i++) begin
            m_act[i] = 0; m_ch[i] = 0; m_spd[i] = 0; m_y[i] = 0;
        end
    endtask

    task automatic model_step();
        int free_i, best_i, lost_n, ny;
        e_rd_act = m_act[rd_lane];
        e_rd_ch  = m_ch[rd_lane];
        e_rd_y   = m_y[rd_lane];
        if (rst) begin
            e_rd_act = 0; e_rd_ch = 0; e_rd_y = 0;
            m_state = 0; m_score = 0; m_misses = 0;
            model_clear_slots();
            return;
        end
        case (m_state)
            0: if (start) begin
                m_state = 1; m_score = 0; m_misses = 0;
                model_clear_slots();
            end
            1: begin
                free_i = -1;
                for (int i = 0; i < LANES; i++)
                    if (m_act[i] == 0 && free_i < 0) free_i = i;
                best_i = -1;
                if (key_valid)
                    for (int i = 0; i < LANES; i++)
                        if (m_act[i] != 0 && m_ch[i] == int'(key_char))
                            if (best_i < 0 || m_y[i] > m_y[best_i]) best_i = i;
                if (best_i >= 0) begin
                    m_act[best_i] = 0;
                    if (m_score < 255) m_score++;
                end
                lost_n = 0;
                if (tick)
                    for (int i = 0; i < LANES; i++)
                        if (m_act[i] != 0) begin
                            ny = m_y[i] + m_spd[i];
                            if (ny >= BOTTOM || ny >= (1 << Y_W)) begin
                                m_act[i] = 0;
                                lost_n++;
                            end else begin
                                m_y[i] = ny;
                            end
                        end
                if (spawn_valid && free_i >= 0) begin
                    m_act[free_i] = 1;
                    m_ch[free_i]  = int'(spawn_char);
                    m_spd[free_i] = (spawn_speed == 0) ? 1 : int'(spawn_speed);
                    m_y[free_i]   = int'(spawn_y);
                end
                m_misses += lost_n;
                if (m_misses > MISS_LIMIT) m_misses = MISS_LIMIT;
                if (m_misses == MISS_LIMIT) m_state = 2;
            end
            default: if (start) m_state = 0;
        endcase
    endtask

    task automatic compare_all();
        int any_free;
        any_free = 0;
        for (int i = 0; i < LANES; i++) if (m_act[i] == 0) any_free = 1;
        checkOutput("state", int'(state), m_state);
        checkOutput("score", int'(score), m_score);
        checkOutput("misses", int'(misses), m_misses);
        checkOutput("gameover", int'(gameover), (m_state == 2) ? 1 : 0);
        checkOutput("spawn_ready", int'(spawn_ready), (m_state == 1 && any_free != 0) ? 1 : 0);
        checkOutput("rd_active", int'(rd_active), e_rd_act);
        if (e_rd_act != 0) begin
            checkOutput("rd_char", int'(rd_char), e_rd_ch);
            checkOutput("rd_y", int'(rd_y), e_rd_y);
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic applyStimulus(input logic st, input logic tk, input logic sv,
                                 input logic [7:0] sch, input int ssp, input int sy,
                                 input logic kv, input logic [7:0] kch);
        start       = st;
        tick        = tk;
        spawn_valid = sv;
        spawn_char  = sch;
        spawn_speed = SPD_W'(ssp);
        spawn_y     = Y_W'(sy);
        key_valid   = kv;
        key_char    = kch;
    endtask

    task automatic do_cycle(input logic st, input logic tk, input logic sv,
                            input logic [7:0] sch, input int ssp, input int sy,
                            input logic kv, input logic [7:0] kch);
        rd_lane = rd_lane + 1'b1;
        applyStimulus(st, tk, sv, sch, ssp, sy, kv, kch);
        run_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    endtask

    task automatic do_start();
        do_cycle(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    endtask

    task automatic do_spawn(input logic [7:0] ch, input int y, input int spd);
        do_cycle(0, 0, 1, ch, spd, y, 0, 8'h00);
    endtask

    task automatic do_key(input logic [7:0] ch);
        do_cycle(0, 0, 0, 8'h00, 0, 0, 1, ch);
    endtask

    task automatic do_tick();
        do_cycle(0, 1, 0, 8'h00, 0, 0, 0, 8'h00);
    endtask

    task automatic peek(input int lane);
        rd_lane = 2'(lane);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        run_cycle();
    endtask

    initial begin
        model_clear_slots();
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        rst = 1'b1;
        run_cycle();
        run_cycle();
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_score", int'(score), 0);
        checkOutput("reset_gameover", int'(gameover), 0);
        checkOutput("reset_spawn_ready", int'(spawn_ready), 0);
        checkOutput("reset_rd_active", int'(rd_active), 0);
        rst = 1'b0;
        idle(1);

        do_start();
        checkOutput("start_state", int'(state), 1);
        checkOutput("start_spawn_ready", int'(spawn_ready), 1);
        checkOutput("start_misses", int'(misses), 0);
        do_start();
        checkOutput("start_in_play", int'(state), 1);

        // Deepest 'A' goes first, then the shallower one.
        do_spawn("A", 200, 1);
        do_spawn("X", 50, 1);
        do_spawn("A", 100, 1);
        do_key("A");
        checkOutput("match_deepest_score", int'(score), 1);
        peek(0);
        checkOutput("match_lane0_gone", int'(rd_active), 0);
        peek(2);
        checkOutput("match_lane2_kept", int'(rd_active), 1);
        checkOutput("match_lane2_y", int'(rd_y), 100);
        do_key("A");
        checkOutput("match_second_score", int'(score), 2);
        peek(2);
        checkOutput("match_lane2_gone", int'(rd_active), 0);
        do_key("X");

        do_spawn("Q", 10, 1);
        do_spawn("Q", 10, 1);
        do_key("Q");
        peek(0);
        checkOutput("tie_lane0_gone", int'(rd_active), 0);
        peek(1);
        checkOutput("tie_lane1_kept", int'(rd_active), 1);
        do_key("Q");
        do_key("Z");
        checkOutput("no_candidate_score", int'(score), 5);

        do_spawn("A", 0, 1);
        do_spawn("B", 0, 1);
        do_spawn("C", 0, 1);
        do_spawn("D", 0, 1);
        checkOutput("full_spawn_ready", int'(spawn_ready), 0);
        do_spawn("E", 0, 1);
        for (int i = 0; i < LANES; i++) begin
            peek(i);
            checkOutput("full_lane_active", int'(rd_active), 1);
            checkOutput("full_lane_char", int'(rd_char), 65 + i);
        end
        do_key("A");
        do_key("B");
        do_key("C");
        do_key("D");
        checkOutput("cleared_score", int'(score), 9);

        do_spawn("M", 478, 7);
        do_cycle(0, 1, 1, "N", 2, 30, 1, "M");
        checkOutput("same_cycle_score", int'(score), 10);
        checkOutput("same_cycle_misses", int'(misses), 0);
        checkOutput("same_cycle_state", int'(state), 1);
        peek(1);
        checkOutput("same_cycle_spawn_active", int'(rd_active), 1);
        checkOutput("same_cycle_spawn_y", int'(rd_y), 30);
        peek(0);
        checkOutput("same_cycle_freed", int'(rd_active), 0);
        do_tick();
        peek(1);
        checkOutput("tick_advance_y", int'(rd_y), 32);
        do_spawn("S", 5, 0);
        do_tick();
        peek(0);
        checkOutput("speed_zero_as_one", int'(rd_y), 6);
        peek(1);
        checkOutput("speed_two_y", int'(rd_y), 34);

        for (int i = 0; i < 260; i++) do_cycle(0, 0, 1, "K", 1, 0, 1, "K");
        do_key("K");
        checkOutput("score_saturate", int'(score), 255);

        do_spawn("P", 475, 5);
        do_tick();
        checkOutput("miss_count", int'(misses), 1);
        checkOutput("miss_over_state", int'(state), 2);
        checkOutput("miss_gameover", int'(gameover), 1);
        do_cycle(0, 1, 1, "T", 1, 0, 1, "S");
        peek(0);
        checkOutput("over_frozen_active", int'(rd_active), 1);
        checkOutput("over_frozen_y", int'(rd_y), 7);
        checkOutput("over_frozen_score", int'(score), 255);

        do_start();
        checkOutput("over_to_welcome", int'(state), 0);
        checkOutput("welcome_gameover", int'(gameover), 0);
        do_start();
        checkOutput("restart_score", int'(score), 0);
        checkOutput("restart_misses", int'(misses), 0);
        peek(0);
        checkOutput("restart_cleared", int'(rd_active), 0);

        do_spawn("U", 479, 1);
        do_spawn("V", 1020, 7);
        do_spawn("W", 10, 1);
        do_cycle(0, 1, 0, 8'h00, 0, 0, 1, "W");
        checkOutput("final_miss_score", int'(score), 1);
        checkOutput("final_miss_clamp", int'(misses), 1);
        checkOutput("final_miss_state", int'(state), 2);

        do_start();
        do_start();
        do_spawn("R", 3, 1);
        do_spawn("R", 3, 1);
        do_key("R");
        checkOutput("pre_reset_score", int'(score), 1);
        rd_lane = 2'd1;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        run_cycle();
        rst = 1'b0;
        checkOutput("midreset_state", int'(state), 0);
        checkOutput("midreset_score", int'(score), 0);
        checkOutput("midreset_spawn_ready", int'(spawn_ready), 0);
        checkOutput("midreset_rd_active", int'(rd_active), 0);
        checkOutput("midreset_rd_char", int'(rd_char), 0);
        checkOutput("midreset_rd_y", int'(rd_y), 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
